// File: rtl/mem_bist_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bist_ctrl
//   March-style built-in self-test controller for a single-port synchronous
//   memory (DW x 2**AW, registered read, write and read mutually exclusive).
//   A test runs two passes. Each pass writes a seed-derived pattern to every
//   address and then reads every address back and compares it. Pass 1 uses
//   the bitwise inverse of the pass 0 pattern.
//
// Ports
//   clk, rst      : clock shared with the memory, async active-high reset
//   start, abort  : launch a test (sampled in IDLE) / terminate a running test
//   seed          : pattern seed, captured when start is accepted
//   busy, done    : test in progress / test completed without abort
//   pass          : valid with done, 1 when no miscompare was seen
//   err_count     : saturating miscompare count
//   fail_addr     : address of the first miscompare (0 if none)
//   mem_write, mem_read, mem_addr, mem_data_in : memory request side
//   mem_data_out  : memory read data, valid the cycle after a read strobe
// -----------------------------------------------------------------------------
module mem_bist_ctrl #(
    parameter int DW = 8,
    parameter int AW = 5,
    parameter int EW = AW + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [EW-1:0] err_count,
    output logic [AW-1:0] fail_addr,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = '1;
    localparam logic [EW-1:0] ERR_MAX   = '1;

    state_t        state;
    logic          pass_idx;
    logic [DW-1:0] seed_r;
    logic          chk_vld;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] chk_exp;

    // Expected word for address a in pass p: zero-extended address XOR seed,
    // inverted in the second pass.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a,
                                              input logic          p,
                                              input logic [DW-1:0] s);
        logic [DW-1:0] v;
        v = DW'(a) ^ s;
        return p ? ~v : v;
    endfunction

    // NOTE: every register here is updated with <= so all reads in this block
    // see the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pass_idx    <= 1'b0;
            seed_r      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            chk_vld     <= 1'b0;
            chk_addr    <= '0;
            chk_exp     <= '0;
        end else begin
            // The check stage only stays valid while RD keeps re-arming it;
            // this makes it drop the cycle after the last read.
            chk_vld <= 1'b0;

            // Compare the read issued two edges ago. An abort discards the
            // in-flight compare together with the rest of the test.
            if (chk_vld && !abort && (mem_data_out != chk_exp)) begin
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                // Count never returns to zero once non-zero, so zero means
                // this is the first miscompare since start.
                if (err_count == '0) fail_addr <= chk_addr;
            end

            if (state != IDLE && abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                mem_write <= 1'b0;
                mem_read  <= 1'b0;
                mem_addr  <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            seed_r      <= seed;
                            done        <= 1'b0;
                            pass        <= 1'b0;
                            err_count   <= '0;
                            fail_addr   <= '0;
                            pass_idx    <= 1'b0;
                            busy        <= 1'b1;
                            mem_write   <= 1'b1;
                            mem_addr    <= '0;
                            mem_data_in <= pattern('0, 1'b0, seed);
                            state       <= WR;
                        end
                    end
                    WR: begin
                        if (mem_addr == LAST_ADDR) begin
                            mem_write <= 1'b0;
                            mem_read  <= 1'b1;
                            mem_addr  <= '0;
                            state     <= RD;
                        end else begin
                            mem_addr    <= mem_addr + 1'b1;
                            mem_data_in <= pattern(mem_addr + 1'b1, pass_idx, seed_r);
                        end
                    end
                    RD: begin
                        chk_vld  <= 1'b1;
                        chk_addr <= mem_addr;
                        chk_exp  <= pattern(mem_addr, pass_idx, seed_r);
                        if (mem_addr == LAST_ADDR) begin
                            mem_read <= 1'b0;
                            mem_addr <= '0;
                            state    <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (!pass_idx) begin
                            pass_idx    <= 1'b1;
                            mem_write   <= 1'b1;
                            mem_addr    <= '0;
                            mem_data_in <= pattern('0, 1'b1, seed_r);
                            state       <= WR;
                        end else begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        // err_count already includes the compare done in DRAIN.
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Upstream master and downstream checker for the single-port synchronous memory (DW x 2**AW, registered read, write and read mutually exclusive).
- On start, it runs a two-pass march over every address. Each pass writes a data pattern to all addresses, then reads every address back and compares against the expected value.
- Reports done, pass/fail, error count and first failing address. Used for power-on memory self-test and for regression of memory models.

Parameters:
- DW, 8, memory data width in bits.
- AW, 5, memory address width; depth = 2**AW.
- EW, AW+2, error counter width.

Ports:
- clk  input  1  rising-edge clock shared with the memory.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch a test; sampled only in IDLE.
- abort  input  1  terminate a running test.
- seed  input  DW  pattern seed; captured when start is accepted.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  test completed without abort; held until the next accepted start.
- pass  output  1  valid when done=1; 1 if err_count==0.
- err_count  output  EW  number of miscompares; saturating.
- fail_addr  output  AW  address of the first miscompare; 0 if none.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- mem_addr  output  AW  memory address.
- mem_data_in  output  DW  memory write data.
- mem_data_out  input  DW  memory read data; valid the cycle after a read strobe.

Behaviour:
- Reset (asynchronous): state=IDLE and all outputs 0. This includes mem_write, mem_read, done, pass, err_count and fail_addr. Reset during a test abandons it with no report.
- States: IDLE, WR, RD, DRAIN, FIN.
- IDLE:
  - start=1 captures seed, clears done/pass/err_count/fail_addr, sets pass index p=0 and addr=0, then enters WR.
  - Strobes stay low.
- Expected data: exp(a,p) = (zero-extended a) XOR seed, truncated to DW. For p=1 the value is bitwise inverted.
- WR:
  - mem_write=1, mem_read=0, mem_addr=addr, mem_data_in=exp(addr,p).
  - addr increments each cycle. After addr=2**AW-1, addr wraps to 0 and the state goes to RD.
- RD:
  - mem_read=1, mem_write=0, mem_addr=addr.
  - Each read also registers chk_vld=1, chk_addr=addr and chk_exp=exp(addr,p).
  - After the last address, go to DRAIN.
- Check pipeline:
  - On every cycle with chk_vld=1, compare mem_data_out against chk_exp.
  - On mismatch, err_count increments, saturating at 2**EW-1.
  - If this is the first mismatch since start, fail_addr=chk_addr.
  - chk_vld clears the cycle after the last read.
- DRAIN:
  - One cycle, no strobes; performs the final compare.
  - If p=0: set p=1 and go to WR.
  - If p=1: go to FIN.
- FIN:
  - One cycle; sets done=1 and pass=(err_count==0), including any error counted in DRAIN.
  - Then go to IDLE.
- Latency: start sampled at edge E0 means the first write is driven after E0. done rises 2*(2*2**AW+1)+1 cycles after E0, which is 131 with defaults.
- Strobe invariant: mem_write and mem_read are never high in the same cycle. Both are low outside WR/RD.
- start while busy: ignored.
- abort while busy:
  - Go to IDLE next edge; strobes low next cycle.
  - chk_vld cleared; done stays 0.
  - err_count/fail_addr keep their partial values.
- abort and start together in IDLE: start wins and abort is ignored.
- Address arithmetic is modulo 2**AW. No out-of-range address is ever driven.

Test Plan:
- Fault-free memory, seed=0x00, start pulse: 64 writes (0x00..0x1F, then 0xFF..0xE0) and 64 reads occur. done=1 at edge 131, pass=1, err_count=0, fail_addr=0.
- Memory with bit0 stuck-at-0 at addr 5, seed=0x00:
  - Pass 0 expects 0x05, reads 0x04, so 1 error. Pass 1 expects 0xFA, no error.
  - Required result: err_count=1, fail_addr=5, pass=0.
- seed=0xA5, fault-free: the write at addr 3 in pass 0 is 0xA6 and in pass 1 is 0x59. pass=1.
- abort asserted 40 cycles after start: strobes low the next cycle, busy=0, done=0. A subsequent start completes normally with pass=1.
- rst pulsed mid-RD of pass 1: all outputs immediately 0. A start 2 cycles after rst release runs the full 131-cycle test.
- start held high continuously: exactly one test per IDLE visit; start is ignored while busy. Assert mem_write & mem_read never both 1 throughout.
